cpu_boot_loader: RTL
====================

# cpu_boot_loader

Program loader and run controller for the single-cycle CPU. It accepts instruction words over a valid/ready stream and writes them into instruction memory while the CPU is held in reset. It then releases the CPU for a fixed number of cycles and signals completion so the bench or host can sample the register file. It is the write side of program execution, complementing the result dump that reads the register file after a fixed cycle count.

## Interface
Parameters:
- ADDR_W, 5: instruction-memory word-address width (2^ADDR_W words)
- RUN_CYCLES, 25: CPU cycles with reset released before done

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- wdata_i  in  32  instruction word
- wvalid_i  in  1  wdata_i/wlast_i valid
- wlast_i  in  1  current word is the final program word
- wready_o  out  1  loader accepts a word this cycle
- im_we_o  out  1  instruction-memory write enable (registered)
- im_addr_o  out  ADDR_W  instruction-memory word address (registered)
- im_wdata_o  out  32  instruction-memory write data (registered)
- cpu_rst_n_o  out  1  drives the CPU reset input rst_i, which is active-low
- busy_o  out  1  CPU running
- done_o  out  1  run complete, level
- ovf_o  out  1  sticky: memory filled without wlast_i
- word_cnt_o  out  ADDR_W+1  words written
- cyc_cnt_o  out  16  CPU cycles elapsed in RUN

## Operation
- States: LOAD, FLUSH, RUN, DONE. Reset enters LOAD.
- LOAD: wready_o=1. Handshake = wvalid_i & wready_o.
  - Each handshake registers the word: next cycle im_we_o=1, im_addr_o=word_cnt_o (pre-increment), im_wdata_o=wdata_i; word_cnt_o increments.
  - A handshake with wlast_i=1 goes to FLUSH.
  - A handshake that writes address 2^ADDR_W-1 without wlast_i also goes to FLUSH and sets ovf_o.
- FLUSH: one cycle. wready_o=0. The final write completes (im_we_o=1). Then goes to RUN.
- RUN: cpu_rst_n_o=1, busy_o=1, cyc_cnt_o increments every cycle from 0. When cyc_cnt_o==RUN_CYCLES-1, goes to DONE.
- DONE: terminal until rst_i. done_o=1, busy_o=0. cpu_rst_n_o stays 1. cyc_cnt_o holds RUN_CYCLES. wready_o=0; wvalid_i is ignored.
- im_we_o=0 in every cycle not following a handshake. im_addr_o/im_wdata_o hold their last value.
- A zero-word program is impossible: the first accepted word is always written, even when wlast_i=1.
- Counter widths: word_cnt_o never exceeds 2^ADDR_W. cyc_cnt_o saturates and never wraps. RUN_CYCLES must be ≤ 65535.

## Timing
- Reset values: wready_o=0 in the reset cycle and 1 from the first cycle after. im_we_o=0, im_addr_o=0, im_wdata_o=0, cpu_rst_n_o=0, busy_o=0, done_o=0, ovf_o=0, word_cnt_o=0, cyc_cnt_o=0.
- Write latency: handshake at edge k gives im_we_o high during cycle k+1. Back-to-back handshakes every cycle are supported.
- Last handshake at edge k: FLUSH in cycle k+1. cpu_rst_n_o rises at edge k+2. done_o rises at edge k+2+RUN_CYCLES.
- The CPU therefore never leaves reset before its final instruction is written.
- rst_i asserted in any state, including mid-load or mid-run: the next edge restores all reset values and cpu_rst_n_o drops to 0 immediately (registered). Instruction-memory contents are not cleared.
- wvalid_i low in LOAD: no state change and no write. Gaps of any length are allowed.

## Structure
- Shared package cpu_boot_pkg: state enum (LOAD, FLUSH, RUN, DONE), default RUN_CYCLES, instruction width 32.
- One sub-module, sat_counter: a parameterised width up-counter with enable, synchronous clear and saturation. It is instantiated for both word_cnt_o and cyc_cnt_o.
- The top level holds the FSM and the registered write port.

## Test plan
- Load 4 words 0x20010005, 0x20020003, 0x00221820, 0x00000000 back-to-back, last with wlast_i → im_we_o high 4 cycles at addresses 0..3; cpu_rst_n_o rises 2 cycles after the last handshake; done_o rises 25 cycles later; cyc_cnt_o=25.
- Same program with wvalid_i low for 3 cycles between words → identical writes and addresses, no spurious im_we_o, same run length.
- Single word with wlast_i=1 → one write at address 0; word_cnt_o=1; FLUSH then RUN.
- 32 words with no wlast_i (ADDR_W=5) → last write at address 31; ovf_o=1; word_cnt_o=32; RUN entered.
- rst_i pulsed at RUN cycle 10 → next cycle cpu_rst_n_o=0, state LOAD, cyc_cnt_o=0, done_o=0; reloading works.
- In DONE, drive wvalid_i=1 → wready_o=0, no writes, counters unchanged.

Source files
------------

// File: rtl/cpu_boot_pkg.sv
// Shared types and constants for the CPU boot loader.
// Holds the loader state encoding and the default run length.
package cpu_boot_pkg;

    localparam int unsigned INSTR_W            = 32;
    localparam int unsigned CYC_W              = 16;
    localparam int unsigned DEFAULT_RUN_CYCLES = 25;

    typedef enum logic [1:0] {
        StLoad,
        StFlush,
        StRun,
        StDone
    } boot_state_e;

endpackage

// File: rtl/cpu_boot_loader_sat_counter.sv
// Up-counter with enable and synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_boot_loader.sv
// Streams a program into instruction memory with the CPU held in reset,
// then releases the CPU for a fixed number of cycles and flags completion.
module cpu_boot_loader
    import cpu_boot_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned RUN_CYCLES = DEFAULT_RUN_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic               wvalid_i,
    input  logic               wlast_i,
    output logic               wready_o,
    output logic               im_we_o,
    output logic [ADDR_W-1:0]  im_addr_o,
    output logic [INSTR_W-1:0] im_wdata_o,
    output logic               cpu_rst_n_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               ovf_o,
    output logic [ADDR_W:0]    word_cnt_o,
    output logic [CYC_W-1:0]   cyc_cnt_o
);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(RUN_CYCLES - 1);

    boot_state_e        r_state;
    boot_state_e        w_state_next;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [INSTR_W-1:0] r_wdata;
    logic               r_cpu_rst_n;
    logic               r_ovf;
    logic               w_hs;
    logic               w_full;
    logic               w_cyc_en;
    logic               w_cyc_last;
    logic [ADDR_W:0]    w_word_cnt;
    logic [CYC_W-1:0]   w_cyc_cnt;

    // Masked by rst_i so the reset cycle never advertises readiness.
    assign wready_o   = (r_state == StLoad) && !rst_i;
    assign w_hs       = wvalid_i && wready_o;
    assign w_full     = (w_word_cnt[ADDR_W-1:0] == {ADDR_W{1'b1}});
    // Cycles are counted only once the CPU has actually left reset.
    assign w_cyc_en   = (r_state == StRun) && r_cpu_rst_n;
    assign w_cyc_last = w_cyc_en && (w_cyc_cnt == CYC_LAST);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StLoad:  if (w_hs && (wlast_i || w_full)) w_state_next = StFlush;
            StFlush: w_state_next = StRun;
            StRun:   if (w_cyc_last) w_state_next = StDone;
            StDone:  w_state_next = StDone;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ovf       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_we        <= w_hs;
            r_cpu_rst_n <= (r_state == StRun) || (r_state == StDone);
            if (w_hs) begin
                r_addr  <= w_word_cnt[ADDR_W-1:0];
                r_wdata <= wdata_i;
                if (w_full && !wlast_i) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .WIDTH (ADDR_W + 1)
    ) u_word_cnt (
        .i_clk (clk_i),
        .i_clr (rst_i),
        .i_en  (w_hs),
        .o_cnt (w_word_cnt)
    );

    sat_counter #(
        .WIDTH (CYC_W)
    ) u_cyc_cnt (
        .i_clk (clk_i),
        .i_clr (rst_i),
        .i_en  (w_cyc_en),
        .o_cnt (w_cyc_cnt)
    );

    assign im_we_o     = r_we;
    assign im_addr_o   = r_addr;
    assign im_wdata_o  = r_wdata;
    assign cpu_rst_n_o = r_cpu_rst_n;
    assign busy_o      = (r_state == StRun) && r_cpu_rst_n;
    assign done_o      = (r_state == StDone);
    assign ovf_o       = r_ovf;
    assign word_cnt_o  = w_word_cnt;
    assign cyc_cnt_o   = w_cyc_cnt;

endmodule
